wb_arbiter: RTL and testbench

// Shares the single register-file write port between the execute writeback (ex) and
// the memory/load writeback (mem). Ex has fixed priority and is never stalled. Mem

---
 rtl/wb_arbiter_if.sv | 39 +++
 rtl/wb_arbiter.sv | 115 +++++++++++
 tb/tb_wb_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Register-file write-port arbitration bus: ex/mem write requests, read-hazard
// lookups, the registered register-file write port and FIFO occupancy.
interface wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: ex is always accepted; a mem write transfers on a cycle where
  // mem_valid && mem_ready, and mem_ready never looks at mem_valid.
  logic            ex_valid;
  logic [AW-1:0]   ex_addr;
  logic [XLEN-1:0] ex_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_data;
  logic [AW-1:0]   rd_addr1;
  logic [AW-1:0]   rd_addr2;
  logic            hazard1;
  logic            hazard2;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [CW-1:0]   count;

  modport slave (
    input  ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data,
           rd_addr1, rd_addr2,
    output mem_ready, hazard1, hazard2, rf_we, rf_waddr, rf_wdata, count
  );

  modport master (
    output ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data,
           rd_addr1, rd_addr2,
    input  mem_ready, hazard1, hazard2, rf_we, rf_waddr, rf_wdata, count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ex has fixed priority on the register-file write port;
// mem writes that lose are buffered in a small FIFO and drained when ex idles.
// Buffered writes that are overwritten by a younger ex write are killed, and
// reads of live buffered addresses are flagged as hazards.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]   ent_addr [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   cnt;

  logic ex_issue;
  logic fifo_ne;
  logic mem_take;
  logic mem_kill;
  logic pop;
  logic bypass;
  logic push;
  logic haz1;
  logic haz2;

  // Issue decision for this cycle; x0 requests are accepted but never written.
  always_comb begin
    ex_issue = bus.ex_valid && (bus.ex_addr != '0);
    fifo_ne  = (cnt != '0);
    mem_take = bus.mem_valid && bus.mem_ready && (bus.mem_addr != '0);
    // Same-cycle mem write to the ex target is older, so the ex value wins.
    mem_kill = ex_issue && (bus.mem_addr == bus.ex_addr);
    pop      = !ex_issue && fifo_ne;
    bypass   = !ex_issue && !fifo_ne && mem_take;
    push     = mem_take && !mem_kill && !bypass;
  end

  // Hazard lookup over live buffered entries; x0 never hazards.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (ent_addr[i] == bus.rd_addr1)) haz1 = 1'b1;
      if (live[i] && (ent_addr[i] == bus.rd_addr2)) haz2 = 1'b1;
    end
    if (bus.rd_addr1 == '0) haz1 = 1'b0;
    if (bus.rd_addr2 == '0) haz2 = 1'b0;
  end

  assign bus.mem_ready = (cnt < CW'(DEPTH));
  assign bus.hazard1   = haz1;
  assign bus.hazard2   = haz2;
  assign bus.count     = cnt;

  // Registered write port plus FIFO state; push and pop never touch the same slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      live         <= '0;
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (ex_issue) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= bus.ex_addr;
        bus.rf_wdata <= bus.ex_data;
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_addr[i] == bus.ex_addr) live[i] <= 1'b0;
        end
      end else if (fifo_ne) begin
        // A killed head still drains its slot but writes nothing.
        bus.rf_we    <= live[head];
        bus.rf_waddr <= ent_addr[head];
        bus.rf_wdata <= ent_data[head];
        live[head]   <= 1'b0;
        head         <= head + PW'(1);
      end else if (mem_take) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= bus.mem_addr;
        bus.rf_wdata <= bus.mem_data;
      end else begin
        bus.rf_we    <= 1'b0;
      end

      // Later assignment overrides any kill that matched the stale tail slot.
      if (push) begin
        ent_addr[tail] <= bus.mem_addr;
        ent_data[tail] <= bus.mem_data;
        live[tail]     <= 1'b1;
        tail           <= tail + PW'(1);
      end

      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by randomized traffic, all
// checked against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    bit              live;
  } ent_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ent_t mq[$];
  logic [AW+XLEN-1:0] exp_q[$];

  wb_arbiter_if #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic set_idle();
    bus.ex_valid  = 1'b0;
    bus.ex_addr   = '0;
    bus.ex_data   = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
  endtask

  // Pull reset low away from the clock edge and check the async clear at once.
  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    #1;
    check_eq("rst_rf_we", bus.rf_we, 0);
    check_eq("rst_rf_waddr", bus.rf_waddr, 0);
    check_eq("rst_rf_wdata", bus.rf_wdata, 0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_mem_ready", bus.mem_ready, 1);
    check_eq("rst_hazard1", bus.hazard1, 0);
    check_eq("rst_hazard2", bus.hazard2, 0);
    mq.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic bit model_hazard(input logic [AW-1:0] a);
    bit h = 1'b0;
    if (a == '0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == a) h = 1'b1;
    return h;
  endfunction

  // One bus cycle: drive, check combinational outputs, advance the model,
  // then check the registered write one edge later.
  task automatic drive(input bit exv, input logic [AW-1:0] exa, input logic [XLEN-1:0] exd,
                       input bit mv, input logic [AW-1:0] ma, input logic [XLEN-1:0] md,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2, output bit acc);
    bit exp_ready;
    bit exp_we;
    bit do_push;
    ent_t e;
    logic [AW+XLEN-1:0] w;

    bus.ex_valid  = exv;
    bus.ex_addr   = exa;
    bus.ex_data   = exd;
    bus.mem_valid = mv;
    bus.mem_addr  = ma;
    bus.mem_data  = md;
    bus.rd_addr1  = r1;
    bus.rd_addr2  = r2;
    #1;
    exp_ready = (mq.size() < DEPTH);
    check_eq("mem_ready", bus.mem_ready, exp_ready);
    check_eq("hazard1", bus.hazard1, model_hazard(r1));
    check_eq("hazard2", bus.hazard2, model_hazard(r2));
    check_eq("count", bus.count, mq.size());

    acc     = mv && exp_ready;
    exp_we  = 1'b0;
    w       = '0;
    do_push = acc && (ma != '0);
    if (exv && exa != '0) begin
      exp_we = 1'b1;
      w = {exa, exd};
      foreach (mq[i]) if (mq[i].addr == exa) mq[i].live = 1'b0;
      if (ma == exa) do_push = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_we = e.live;
      w = {e.addr, e.data};
    end else if (do_push) begin
      exp_we = 1'b1;
      w = {ma, md};
      do_push = 1'b0;
    end
    if (do_push) mq.push_back('{addr: ma, data: md, live: 1'b1});
    if (exp_we) exp_q.push_back(w);

    @(posedge clk);
    #1;
    check_eq("rf_we", bus.rf_we, exp_we);
    if (exp_we) begin
      w = exp_q.pop_front();
      if (bus.rf_we) begin
        check_eq("rf_waddr", bus.rf_waddr, w[AW+XLEN-1:XLEN]);
        check_eq("rf_wdata", bus.rf_wdata, w[XLEN-1:0]);
      end
    end
  endtask

  initial begin
    bit acc;
    int idx;
    logic [AW-1:0] t3_addr [3];

    rst = 1'b1;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    set_idle();
    #3;
    do_reset();

    // T1: lone mem write bypasses the FIFO
    drive(0, 0, 0, 1, 5'd3, 32'h11, 0, 0, acc);
    check_eq("t1_wdata", bus.rf_wdata, 32'h11);
    check_eq("t1_count", bus.count, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, acc);

    // T2: collision, mem buffered behind ex and flagged as hazard
    drive(1, 5'd5, 32'hAA, 1, 5'd6, 32'hBB, 5'd6, 0, acc);
    check_eq("t2_count", bus.count, 1);
    check_eq("t2_hazard", bus.hazard1, 1);
    drive(0, 0, 0, 0, 0, 0, 5'd6, 0, acc);
    check_eq("t2_waddr", bus.rf_waddr, 6);
    check_eq("t2_hazard_clear", bus.hazard1, 0);

    // T3: FIFO fills while ex is busy; mem advances only when accepted
    t3_addr[0] = 5'd8;
    t3_addr[1] = 5'd9;
    t3_addr[2] = 5'd10;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 3)
        drive(c < 4, 5'd1 + 5'(c), 32'h100 + c, 1, t3_addr[idx], 32'h200 + idx, 5'd9, 5'd10, acc);
      else
        drive(c < 4, 5'd1 + 5'(c), 32'h100 + c, 0, 0, 0, 5'd9, 5'd10, acc);
      if (acc) idx++;
    end
    check_eq("t3_all_accepted", idx, 3);

    // T4: WAW kill of a buffered mem write
    drive(1, 5'd4, 32'h44, 1, 5'd7, 32'h22, 5'd7, 0, acc);
    drive(1, 5'd7, 32'h01, 0, 0, 0, 5'd7, 0, acc);
    check_eq("t4_hazard_drop", bus.hazard1, 0);
    drive(0, 0, 0, 0, 0, 0, 5'd7, 0, acc);
    check_eq("t4_killed_pop", bus.rf_we, 0);

    // T5: x0 requests from both sides
    drive(1, 5'd0, 32'h66, 1, 5'd0, 32'h55, 0, 0, acc);
    check_eq("t5_accept", acc, 1);
    check_eq("t5_count", bus.count, 0);

    // T6: reset with two buffered writes
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 5'd2, 5'd3, acc);
    drive(1, 5'd4, 32'h4, 1, 5'd3, 32'h3, 5'd2, 5'd3, acc);
    check_eq("t6_count_full", bus.count, 2);
    check_eq("t6_not_ready", bus.mem_ready, 0);
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 5'd2, 5'd3, acc);

    // Randomized traffic over a small address range to force collisions
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      drive($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
    end
    for (int c = 0; c < 4; c++) drive(0, 0, 0, 0, 0, 0, 0, 0, acc);
    check_eq("drained", bus.count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
